avalon_pio_responder: RTL and testbench
=======================================

Name: avalon_pio_responder

Overview:
- Avalon-MM responder (slave) peripheral that the Nios II data master reads and writes over the SoC interconnect.
- Replaces the stock switch, LED and accumulate-key PIOs with one register block.
- Synchronizes the 8 switches and the active-low accumulate key, and debounces the key.
- Captures key-press edges into a sticky register and raises a maskable interrupt to the CPU.

Parameters:
- DATA_W, 32, Avalon readdata/writedata width.
- SW_W, 8, switch/LED field width.
- DEBOUNCE_CYCLES, 500000, cycles the synchronized key must hold a new level before it is accepted (10 ms at 50 MHz); minimum 2.

Ports:
- clk  in  1  system clock (50 MHz)
- reset  in  1  synchronous, active-high reset
- avs_address  in  2  word address
- avs_read  in  1  read strobe
- avs_write  in  1  write strobe
- avs_writedata  in  DATA_W  write data
- avs_readdata  out  DATA_W  read data, fixed latency 1
- avs_readdatavalid  out  1  high the cycle avs_readdata is valid
- irq  out  1  interrupt request, level
- sw_in  in  SW_W  raw switches, asynchronous
- key_n  in  1  raw accumulate key, active low, asynchronous
- led_out  out  SW_W  LED drive

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high; all state clears on a rising clk edge with reset=1.
- Reset values:
  - avs_readdata=0, avs_readdatavalid=0, irq=0, led_out=0.
  - Edge-capture and mask registers =0.
  - Debouncer stable level =1 (released), counter =0.
  - Synchronizer flops =1 for key, =0 for switches.
- Synchronizers: 2-flop synchronizer on each sw_in bit and on key_n. SW register reflects sw_in 2 cycles late.
- Debouncer states, with cnt counting in 0..DEBOUNCE_CYCLES-1:
  - STABLE: synced key equals stable level; cnt held at 0. A mismatch moves to SETTLING.
  - SETTLING: cnt increments each cycle while the mismatch persists. If the key returns to the stable level, go back to STABLE with cnt=0. When cnt==DEBOUNCE_CYCLES-1 and the mismatch still holds, invert the stable level, set cnt=0 and go to STABLE.
  - press_pulse is 1 for exactly one cycle when the stable level goes 1->0. Release (0->1) produces no pulse.
- Register map, by word address:
  - 0 SW (RO): {zeros, sw_sync}. Writes are ignored.
  - 1 LED (RW): a write loads writedata[SW_W-1:0] into led_out, visible the next cycle. A read returns the current value.
  - 2 EDGE (R/W1C): bit0 sets on press_pulse. Writing 1 to bit0 clears it. Upper bits read 0.
  - 3 MASK (RW): bit0 is the interrupt enable.
- Reads:
  - avs_read in cycle N gives avs_readdatavalid=1 and avs_readdata in cycle N+1.
  - In all other cycles avs_readdatavalid=0 and avs_readdata=0.
  - Reading has no side effects, including EDGE.
  - Back-to-back reads are supported, one per cycle.
- Simultaneous read and write to the same address: the read returns the pre-write value.
- Set/clear collision: press_pulse in the same cycle as a W1C of EDGE bit0 leaves the bit set (set wins).
- Interrupt: irq = edge[0] & mask[0], registered; it updates one cycle after either operand changes. It stays asserted until cleared or masked.
- Reset mid-operation: reset during SETTLING discards the partial count; a pending edge and irq clear immediately on the reset edge.
- Protocol: no waitrequest; the block is always ready. The interconnect never asserts avs_read and avs_write together, so this case needs no defined response.

Decomposition:
- Package pio_responder_pkg:
  - Address constants ADDR_SW=0, ADDR_LED=1, ADDR_EDGE=2, ADDR_MASK=3.
  - Debouncer state enum {STABLE, SETTLING}.
  - DATA_W default.
- Sub-module key_debouncer (synchronizer + debounce FSM + press_pulse), parameterized by DEBOUNCE_CYCLES, instantiated once. Register decode stays in the top module.

Test Plan:
Run all scenarios with DEBOUNCE_CYCLES=4.
1. Reset then read each address.
   - Required: readdatavalid exactly one cycle after each read; data 0 for LED, EDGE and MASK; key synchronizer/debouncer at released; irq=0.
2. sw_in=8'hA5, wait 3 cycles, read addr 0.
   - Required: readdata=32'h000000A5. Change sw_in to 8'h3C; the next read 3 cycles later returns 32'h3C.
3. Write 32'hFFFF_FF5A to addr 1.
   - Required: led_out=8'h5A the next cycle; read addr 1 returns 32'h5A.
4. key_n low for 3 cycles (after sync), then high.
   - Required: no press_pulse and EDGE=0.
   - Then key_n held low for 10 cycles: EDGE bit0=1 once, no second set on release.
   - Required: the bit sets exactly 2 (sync) + 4 (debounce) cycles after the first low sample, ±1.
5. MASK=1, produce a press.
   - Required: irq rises one cycle after EDGE sets.
   - Write 1 to addr 2: irq falls one cycle later.
   - Write 0 to MASK with EDGE set: irq falls and EDGE stays 1.
6. press_pulse in the same cycle as a W1C to EDGE.
   - Required: EDGE remains 1.
   - Reset asserted during SETTLING: EDGE=0 and irq=0 next cycle; no pulse after release of reset.

Source files
------------

// File: rtl/avalon_pio_responder_pkg.sv
// Shared constants and types for the Avalon PIO responder register block.
package pio_responder_pkg;

  localparam int DATA_W_DEF = 32;

  localparam logic [1:0] ADDR_SW   = 2'd0;
  localparam logic [1:0] ADDR_LED  = 2'd1;
  localparam logic [1:0] ADDR_EDGE = 2'd2;
  localparam logic [1:0] ADDR_MASK = 2'd3;

  typedef enum logic {
    STABLE   = 1'b0,
    SETTLING = 1'b1
  } deb_state_t;

endpackage

// File: rtl/avalon_pio_responder_key_debouncer.sv
// Two-flop synchronizer plus debounce FSM for the active-low accumulate key.
// Emits a one-cycle press pulse when the accepted level falls 1->0.
module key_debouncer
  import pio_responder_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic clk,
  input  logic reset,
  input  logic i_key_n,
  output logic o_press_pulse
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          r_key_s1;
  logic          r_key_s2;
  logic          r_stable;
  logic [CW-1:0] r_cnt;
  deb_state_t    r_state;
  logic          w_mismatch;
  logic          w_accept;

  assign w_mismatch = (r_key_s2 != r_stable);
  // The new level is accepted on the cycle the count expires with the mismatch still present.
  assign w_accept      = (r_state == SETTLING) && w_mismatch && (r_cnt == CNT_LAST);
  assign o_press_pulse = w_accept && r_stable;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_key_s1 <= 1'b1;
      r_key_s2 <= 1'b1;
      r_stable <= 1'b1;
      r_cnt    <= '0;
      r_state  <= STABLE;
    end else begin
      r_key_s1 <= i_key_n;
      r_key_s2 <= r_key_s1;
      case (r_state)
        STABLE: begin
          r_cnt <= '0;
          if (w_mismatch) r_state <= SETTLING;
        end
        SETTLING: begin
          if (!w_mismatch) begin
            r_cnt   <= '0;
            r_state <= STABLE;
          end else if (w_accept) begin
            r_stable <= ~r_stable;
            r_cnt    <= '0;
            r_state  <= STABLE;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: begin
          r_cnt   <= '0;
          r_state <= STABLE;
        end
      endcase
    end
  end

endmodule

// File: rtl/avalon_pio_responder.sv
// Avalon-MM register block: synchronized switches, LED drive, key edge capture
// with W1C clear and a maskable level interrupt.
module avalon_pio_responder
  import pio_responder_pkg::*;
#(
  parameter int DATA_W          = DATA_W_DEF,
  parameter int SW_W            = 8,
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [1:0]        avs_address,
  input  logic              avs_read,
  input  logic              avs_write,
  input  logic [DATA_W-1:0] avs_writedata,
  output logic [DATA_W-1:0] avs_readdata,
  output logic              avs_readdatavalid,
  output logic              irq,
  input  logic [SW_W-1:0]   sw_in,
  input  logic              key_n,
  output logic [SW_W-1:0]   led_out
);

  logic [SW_W-1:0]   r_sw_s1;
  logic [SW_W-1:0]   r_sw_s2;
  logic [SW_W-1:0]   r_led;
  logic              r_edge;
  logic              r_mask;
  logic              r_irq;
  logic [DATA_W-1:0] r_rdata;
  logic              r_rvalid;

  logic [DATA_W-1:0] w_rd_mux;
  logic              w_press;
  logic              w_wr_led;
  logic              w_wr_mask;
  logic              w_edge_clr;
  logic              w_unused;

  key_debouncer #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_key_debouncer (
    .clk          (clk),
    .reset        (reset),
    .i_key_n      (key_n),
    .o_press_pulse(w_press)
  );

  assign w_wr_led   = avs_write && (avs_address == ADDR_LED);
  assign w_wr_mask  = avs_write && (avs_address == ADDR_MASK);
  assign w_edge_clr = avs_write && (avs_address == ADDR_EDGE) && avs_writedata[0];
  assign w_unused   = ^avs_writedata[DATA_W-1:SW_W];

  // Mux sees pre-write register values, so a same-cycle read/write returns old data.
  always_comb begin
    w_rd_mux = '0;
    case (avs_address)
      ADDR_SW:   w_rd_mux = DATA_W'(r_sw_s2);
      ADDR_LED:  w_rd_mux = DATA_W'(r_led);
      ADDR_EDGE: w_rd_mux = DATA_W'(r_edge);
      ADDR_MASK: w_rd_mux = DATA_W'(r_mask);
      default:   w_rd_mux = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_sw_s1  <= '0;
      r_sw_s2  <= '0;
      r_led    <= '0;
      r_edge   <= 1'b0;
      r_mask   <= 1'b0;
      r_irq    <= 1'b0;
      r_rdata  <= '0;
      r_rvalid <= 1'b0;
    end else begin
      r_sw_s1  <= sw_in;
      r_sw_s2  <= r_sw_s1;
      r_rvalid <= avs_read;
      r_rdata  <= avs_read ? w_rd_mux : '0;
      if (w_wr_led)  r_led  <= avs_writedata[SW_W-1:0];
      if (w_wr_mask) r_mask <= avs_writedata[0];
      // A press in the same cycle as a clear keeps the bit set.
      if (w_press)         r_edge <= 1'b1;
      else if (w_edge_clr) r_edge <= 1'b0;
      r_irq <= r_edge & r_mask;
    end
  end

  assign avs_readdata      = r_rdata;
  assign avs_readdatavalid = r_rvalid;
  assign irq               = r_irq;
  assign led_out           = r_led;

endmodule

// File: tb/tb_avalon_pio_responder.sv
// Scoreboard bench: driver pushes expected read data, a negedge monitor pops
// and compares; a cycle-level reference model tracks LED, EDGE, MASK and irq.
module tb_avalon_pio_responder;
  import pio_responder_pkg::*;

  localparam int DEB = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  avs_address;
  logic        avs_read;
  logic        avs_write;
  logic [31:0] avs_writedata;
  logic [31:0] avs_readdata;
  logic        avs_readdatavalid;
  logic        irq;
  logic [7:0]  sw_in;
  logic        key_n;
  logic [7:0]  led_out;

  always #5 clk = ~clk;

  avalon_pio_responder #(
    .DATA_W(32), .SW_W(8), .DEBOUNCE_CYCLES(DEB)
  ) dut (
    .clk(clk), .reset(reset), .avs_address(avs_address), .avs_read(avs_read),
    .avs_write(avs_write), .avs_writedata(avs_writedata), .avs_readdata(avs_readdata),
    .avs_readdatavalid(avs_readdatavalid), .irq(irq), .sw_in(sw_in), .key_n(key_n),
    .led_out(led_out)
  );

  int          n_checks = 0;
  int          n_err    = 0;
  logic [31:0] exp_q[$];
  bit          mon_en   = 1'b0;

  // Reference model state (values after the most recent clock edge)
  logic [7:0] m_led, m_sw1, m_sw2;
  logic       m_edge, m_mask, m_irq, m_ks1, m_ks2, m_stable;
  int         m_run;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] model_read(input logic [1:0] a);
    case (a)
      ADDR_SW:   return {24'd0, m_sw2};
      ADDR_LED:  return {24'd0, m_led};
      ADDR_EDGE: return {31'd0, m_edge};
      default:   return {31'd0, m_mask};
    endcase
  endfunction

  // Accepted key level flips once the synchronized key has disagreed with it
  // for DEB+1 consecutive clock samples; a flip to 0 is a press.
  task automatic model_edge(input logic rst, input logic wr, input logic [1:0] a,
                            input logic [31:0] wd);
    logic press, nirq;
    if (rst) begin
      m_led = '0; m_sw1 = '0; m_sw2 = '0; m_edge = 0; m_mask = 0; m_irq = 0;
      m_ks1 = 1; m_ks2 = 1; m_stable = 1; m_run = 0;
    end else begin
      press = 1'b0;
      if (m_ks2 != m_stable) begin
        m_run++;
        if (m_run == DEB + 1) begin
          m_stable = ~m_stable;
          m_run    = 0;
          press    = !m_stable;
        end
      end else m_run = 0;
      m_ks2 = m_ks1; m_ks1 = key_n;
      m_sw2 = m_sw1; m_sw1 = sw_in;
      nirq = m_edge & m_mask;
      if (wr && a == ADDR_LED)  m_led  = wd[7:0];
      if (wr && a == ADDR_MASK) m_mask = wd[0];
      if (press) m_edge = 1'b1;
      else if (wr && a == ADDR_EDGE && wd[0]) m_edge = 1'b0;
      m_irq = nirq;
    end
  endtask

  // One bus cycle; directed reads supply a constant expectation instead of the model's.
  task automatic cyc(input logic rd, input logic wr, input logic [1:0] a,
                     input logic [31:0] wd, input bit use_c, input logic [31:0] cexp);
    logic [31:0] ev;
    avs_read = rd; avs_write = wr; avs_address = a; avs_writedata = wd;
    ev = use_c ? cexp : model_read(a);
    @(posedge clk);
    if (rd && !reset) exp_q.push_back(ev);
    model_edge(reset, wr, a, wd);
    #1;
    avs_read = 1'b0; avs_write = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) cyc(0, 0, 2'd0, 32'd0, 0, 32'd0);
  endtask

  task automatic rdc(input logic [1:0] a, input logic [31:0] e);
    cyc(1, 0, a, 32'd0, 1, e);
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    cyc(0, 1, a, d, 0, 32'd0);
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      if (avs_readdatavalid) begin
        if (exp_q.size() == 0) chk("spurious_rvalid", 32'(avs_readdatavalid), 32'd0);
        else chk("rdata", avs_readdata, exp_q.pop_front());
      end else begin
        chk("rdata_idle", avs_readdata, 32'd0);
      end
      chk("rvalid_missing", 32'(exp_q.size()), 32'd0);
      chk("led", 32'(led_out), 32'(m_led));
      chk("irq", 32'(irq), 32'(m_irq));
    end
  end

  initial begin
    reset = 1'b1; avs_read = 0; avs_write = 0; avs_address = 0; avs_writedata = 0;
    sw_in = 8'h00; key_n = 1'b1;
    idle(1);
    mon_en = 1'b1;
    idle(1);
    reset = 1'b0;

    // Reset state, back-to-back reads of every address
    rdc(ADDR_SW, 32'h0); rdc(ADDR_LED, 32'h0); rdc(ADDR_EDGE, 32'h0); rdc(ADDR_MASK, 32'h0);
    chk("irq_after_reset", 32'(irq), 32'd0);

    // Switch synchronizer
    sw_in = 8'hA5; idle(3); rdc(ADDR_SW, 32'h0000_00A5);
    sw_in = 8'h3C; idle(3); rdc(ADDR_SW, 32'h0000_003C);

    // LED write, then same-cycle read/write returns the old value
    wr(ADDR_LED, 32'hFFFF_FF5A);
    chk("led_next", 32'(led_out), 32'h5A);
    rdc(ADDR_LED, 32'h5A);
    cyc(1, 1, ADDR_LED, 32'h33, 1, 32'h5A);
    rdc(ADDR_LED, 32'h33);

    // Short key glitch is rejected
    key_n = 1'b0; idle(3); key_n = 1'b1; idle(10);
    rdc(ADDR_EDGE, 32'h0);

    // Held press: EDGE sets 6 samples after the first low sample
    key_n = 1'b0;
    for (int k = 0; k < 10; k++) rdc(ADDR_EDGE, 32'((k >= 7)));
    wr(ADDR_EDGE, 32'h1);
    key_n = 1'b1; idle(12);
    rdc(ADDR_EDGE, 32'h0);

    // Interrupt: rises one cycle after EDGE, falls after W1C and after unmask
    wr(ADDR_MASK, 32'h1);
    key_n = 1'b0;
    for (int k = 0; k < 10; k++) begin
      idle(1);
      chk("irq_rise", 32'(irq), 32'((k >= 7)));
    end
    key_n = 1'b1; idle(10);
    wr(ADDR_EDGE, 32'h1);
    chk("irq_hold_w1c", 32'(irq), 32'd1);
    idle(1);
    chk("irq_fall_w1c", 32'(irq), 32'd0);
    key_n = 1'b0; idle(8); key_n = 1'b1; idle(10);
    chk("irq_second", 32'(irq), 32'd1);
    wr(ADDR_MASK, 32'h0);
    chk("irq_hold_mask", 32'(irq), 32'd1);
    idle(1);
    chk("irq_fall_mask", 32'(irq), 32'd0);
    rdc(ADDR_EDGE, 32'h1);

    // Press and W1C in the same cycle: set wins
    wr(ADDR_EDGE, 32'h1);
    key_n = 1'b0; idle(6);
    wr(ADDR_EDGE, 32'h1);
    rdc(ADDR_EDGE, 32'h1);
    key_n = 1'b1; idle(10);

    // Reset during SETTLING clears EDGE/irq and discards the partial count
    wr(ADDR_MASK, 32'h1); idle(2);
    chk("irq_before_reset", 32'(irq), 32'd1);
    key_n = 1'b0; idle(4);
    reset = 1'b1; idle(1); reset = 1'b0;
    chk("irq_on_reset", 32'(irq), 32'd0);
    idle(3); key_n = 1'b1; idle(10);
    rdc(ADDR_EDGE, 32'h0); rdc(ADDR_MASK, 32'h0);

    // Randomized traffic against the reference model
    for (int i = 0; i < 600; i++) begin
      logic [1:0]  a;
      logic [31:0] d;
      int          op;
      if ($urandom_range(7) == 0) key_n = ~key_n;
      if ($urandom_range(15) == 0) sw_in = 8'($urandom);
      a  = 2'($urandom);
      d  = $urandom;
      op = int'($urandom_range(3));
      if ($urandom_range(249) == 0) begin
        reset = 1'b1; idle(1); reset = 1'b0;
      end else if (op == 1 || op == 3) cyc(1, 0, a, 32'd0, 0, 32'd0);
      else if (op == 2) cyc(0, 1, a, d, 0, 32'd0);
      else idle(1);
    end

    idle(3);
    chk("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
    $finish;
  end

endmodule
